// File: rtl/imem_port_arbiter.sv
// Fetch/loader arbiter for the single-port imem: grant + mem strobe same cycle, response exactly 1 cycle later.
// Requests hold until granted; IMEM_ARB_RR_EN selects round-robin, otherwise loader priority with BURST_MAX guard.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module imem_port_arbiter #(
   parameter int BURST_MAX = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   f_req,
   input  logic [`ADDR_SIZE-1:0]  f_addr,
   output logic                   f_gnt,
   output logic                   f_rvalid,
   output logic                   f_err,
   output logic [`WORD_SIZE-1:0]  f_rdata,
   input  logic                   l_req,
   input  logic                   l_we,
   input  logic [`ADDR_SIZE-1:0]  l_addr,
   input  logic [`WORD_SIZE-1:0]  l_wdata,
   output logic                   l_gnt,
   output logic                   l_rvalid,
   output logic                   l_err,
   output logic [`WORD_SIZE-1:0]  l_rdata,
   output logic                   mem_en,
   output logic                   mem_we,
   output logic [`ADDR_SIZE-1:0]  mem_addr,
   output logic [`WORD_SIZE-1:0]  mem_wdata,
   input  logic [`WORD_SIZE-1:0]  mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_RESP_F, S_RESP_L} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_resp_rd;
   logic                    r_resp_err;
   logic                    w_f_win;
   logic                    w_l_win;
   logic                    w_any;
   logic                    w_mis;
   logic [`ADDR_SIZE-1:0]   w_addr;
   logic [`WORD_SIZE-1:0]   w_rdata;

`ifdef IMEM_ARB_RR_EN
   logic r_last_f;

   always_comb begin
      w_f_win = 1'b0;
      w_l_win = 1'b0;
      if (l_req && f_req) begin
         w_l_win = r_last_f;
         w_f_win = !r_last_f;
      end else begin
         w_l_win = l_req;
         w_f_win = f_req;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_last_f <= 1'b1;
      else if (w_l_win)
         r_last_f <= 1'b0;
      else if (w_f_win)
         r_last_f <= 1'b1;
   end
`else
   localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
   logic [7:0] r_burst_cnt;
   logic       w_guard;

   assign w_guard = (r_burst_cnt == BURST_LIM);

   always_comb begin
      w_f_win = 1'b0;
      w_l_win = 1'b0;
      if (l_req && f_req) begin
         w_f_win = w_guard;
         w_l_win = !w_guard;
      end else begin
         w_l_win = l_req;
         w_f_win = f_req;
      end
   end

   // counts only loader wins that kept a waiting fetch out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_burst_cnt <= 8'd0;
      else if (!f_req || w_f_win)
         r_burst_cnt <= 8'd0;
      else if (w_l_win)
         r_burst_cnt <= r_burst_cnt + 8'd1;
   end
`endif

   assign f_gnt  = rst_n & w_f_win;
   assign l_gnt  = rst_n & w_l_win;
   assign w_any  = f_gnt | l_gnt;
   assign w_addr = l_gnt ? l_addr : f_addr;
   assign w_mis  = (w_addr[1:0] != 2'b00);

   assign mem_en    = w_any & ~w_mis;
   assign mem_we    = mem_en & l_gnt & l_we;
   assign mem_addr  = mem_en ? (w_addr >> 2) : '0;
   assign mem_wdata = mem_en ? l_wdata : '0;

   always_comb begin
      w_state_nxt = S_IDLE;
      if (f_gnt)
         w_state_nxt = S_RESP_F;
      else if (l_gnt)
         w_state_nxt = S_RESP_L;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_resp_rd  <= 1'b0;
         r_resp_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_resp_rd  <= w_any & ~(l_gnt & l_we);
         r_resp_err <= w_any & w_mis;
      end
   end

   assign w_rdata  = (r_resp_rd && !r_resp_err) ? mem_rdata : '0;

   assign f_rvalid = rst_n & (r_state == S_RESP_F);
   assign f_err    = f_rvalid & r_resp_err;
   assign f_rdata  = f_rvalid ? w_rdata : '0;
   assign l_rvalid = rst_n & (r_state == S_RESP_L);
   assign l_err    = l_rvalid & r_resp_err;
   assign l_rdata  = l_rvalid ? w_rdata : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small imem model behind the memory port.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_imem_port_arbiter;

   logic                  clk;
   logic                  rst_n;
   logic                  f_req;
   logic [`ADDR_SIZE-1:0] f_addr;
   logic                  f_gnt, f_rvalid, f_err;
   logic [`WORD_SIZE-1:0] f_rdata;
   logic                  l_req, l_we;
   logic [`ADDR_SIZE-1:0] l_addr;
   logic [`WORD_SIZE-1:0] l_wdata;
   logic                  l_gnt, l_rvalid, l_err;
   logic [`WORD_SIZE-1:0] l_rdata;
   logic                  mem_en, mem_we;
   logic [`ADDR_SIZE-1:0] mem_addr;
   logic [`WORD_SIZE-1:0] mem_wdata;
   logic [`WORD_SIZE-1:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   imem_port_arbiter #(.BURST_MAX(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_err(f_err), .f_rdata(f_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_err(l_err), .l_rdata(l_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // imem model: word i starts as A500_00ii except word 2, one-cycle read
   logic [31:0] mem [0:63];
   bit          mem_init_done;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
         mem[2] <= 32'h1234_ABCD;
         mem_init_done <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr[5:0]];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        fr;  logic [31:0] fa;
      logic        lr;  logic lw; logic [31:0] la; logic [31:0] ld;
      logic        fg;  logic lg; logic en; logic we; logic [31:0] ma;
      logic        fv;  logic fe; logic [31:0] fd;
      logic        lv;  logic le; logic [31:0] lrd;
   } vec_t;

   function automatic vec_t mk(
      input logic fr, input logic [31:0] fa,
      input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
      input logic fg, input logic lg, input logic en, input logic we, input logic [31:0] ma,
      input logic fv, input logic fe, input logic [31:0] fd,
      input logic lv, input logic le, input logic [31:0] lrd);
      vec_t v;
      v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
      v.fg = fg; v.lg = lg; v.en = en; v.we = we; v.ma = ma;
      v.fv = fv; v.fe = fe; v.fd = fd; v.lv = lv; v.le = le; v.lrd = lrd;
      return v;
   endfunction

   task automatic drive(input logic fr, input logic [31:0] fa, input logic lr,
                        input logic lw, input logic [31:0] la, input logic [31:0] ld);
      f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_fgnt"}, 32'(f_gnt), 0);
      chk({tag, "_lgnt"}, 32'(l_gnt), 0);
      chk({tag, "_memen"}, 32'(mem_en), 0);
      chk({tag, "_memaddr"}, mem_addr, 0);
      chk({tag, "_frvalid"}, 32'(f_rvalid), 0);
      chk({tag, "_frdata"}, f_rdata, 0);
      chk({tag, "_lrvalid"}, 32'(l_rvalid), 0);
      chk({tag, "_lrdata"}, l_rdata, 0);
   endtask

   vec_t vt [9];

   initial begin
      //              fr fa      lr lw la      ld             fg lg en we ma  fv fe fd             lv le lrd
      vt[0] = mk(0, 0,     0, 0, 0,     0,             0, 0, 0, 0, 0,  0, 0, 0,             0, 0, 0);
      vt[1] = mk(1, 32'h8, 0, 0, 0,     0,             1, 0, 1, 0, 2,  0, 0, 0,             0, 0, 0);
      vt[2] = mk(0, 0,     1, 1, 32'hC, 32'hDEADBEEF,  0, 1, 1, 1, 3,  1, 0, 32'h1234ABCD,  0, 0, 0);
      vt[3] = mk(1, 32'hC, 0, 0, 0,     0,             1, 0, 1, 0, 3,  0, 0, 0,             1, 0, 0);
      vt[4] = mk(1, 32'h6, 0, 0, 0,     0,             1, 0, 0, 0, 0,  1, 0, 32'hDEADBEEF,  0, 0, 0);
      vt[5] = mk(0, 0,     1, 0, 32'h8, 0,             0, 1, 1, 0, 2,  1, 1, 0,             0, 0, 0);
      vt[6] = mk(0, 0,     1, 1, 32'h5, 32'h55,        0, 1, 0, 0, 0,  0, 0, 0,             1, 0, 32'h1234ABCD);
`ifdef IMEM_ARB_RR_EN
      vt[7] = mk(1, 32'h10,1, 0, 32'h14,0,             1, 0, 1, 0, 4,  0, 0, 0,             1, 1, 0);
      vt[8] = mk(0, 0,     0, 0, 0,     0,             0, 0, 0, 0, 0,  1, 0, 32'hA5000004,  0, 0, 0);
`else
      vt[7] = mk(1, 32'h10,1, 0, 32'h14,0,             0, 1, 1, 0, 5,  0, 0, 0,             1, 1, 0);
      vt[8] = mk(0, 0,     0, 0, 0,     0,             0, 0, 0, 0, 0,  0, 0, 0,             1, 0, 32'hA5000005);
`endif

      rst_n = 1'b0;
      drive(1, 32'h8, 1, 1, 32'h4, 32'h1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");

      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         drive(vt[i].fr, vt[i].fa, vt[i].lr, vt[i].lw, vt[i].la, vt[i].ld);
         @(negedge clk);
         chk($sformatf("v%0d_fgnt", i), 32'(f_gnt), 32'(vt[i].fg));
         chk($sformatf("v%0d_lgnt", i), 32'(l_gnt), 32'(vt[i].lg));
         chk($sformatf("v%0d_memen", i), 32'(mem_en), 32'(vt[i].en));
         chk($sformatf("v%0d_memwe", i), 32'(mem_we), 32'(vt[i].we));
         chk($sformatf("v%0d_memaddr", i), mem_addr, vt[i].ma);
         chk($sformatf("v%0d_frvalid", i), 32'(f_rvalid), 32'(vt[i].fv));
         chk($sformatf("v%0d_ferr", i), 32'(f_err), 32'(vt[i].fe));
         chk($sformatf("v%0d_frdata", i), f_rdata, vt[i].fd);
         chk($sformatf("v%0d_lrvalid", i), 32'(l_rvalid), 32'(vt[i].lv));
         chk($sformatf("v%0d_lerr", i), 32'(l_err), 32'(vt[i].le));
         chk($sformatf("v%0d_lrdata", i), l_rdata, vt[i].lrd);
      end

      // both requesters held from a fresh reset
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1, 32'h20, 1, 0, 32'h24, 0);
      for (int k = 0; k < 18; k++) begin
         logic exp_f;
`ifdef IMEM_ARB_RR_EN
         exp_f = (k % 2) == 1;
`else
         exp_f = (k % 9) == 8;
`endif
         if (k > 0) begin
            @(posedge clk); #1;
         end
         @(negedge clk);
         chk($sformatf("burst%0d_fgnt", k), 32'(f_gnt), 32'(exp_f));
         chk($sformatf("burst%0d_lgnt", k), 32'(l_gnt), 32'(!exp_f));
      end

      // loader alone takes every cycle
      @(posedge clk); #1;
      drive(0, 0, 1, 0, 32'h28, 0);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         @(negedge clk);
         chk($sformatf("lonly%0d_lgnt", k), 32'(l_gnt), 1);
         chk($sformatf("lonly%0d_memaddr", k), mem_addr, 10);
      end

      // reset lands on the response cycle of a granted fetch
      @(posedge clk); #1;
      drive(1, 32'h8, 0, 0, 0, 0);
      @(negedge clk);
      chk("rmid_grant", 32'(f_gnt), 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive(1, 32'h8, 1, 0, 32'h8, 0);
      @(negedge clk);
      chk_all_zero("rmid");
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1, 32'h8, 0, 0, 0, 0);
      @(negedge clk);
      chk("rrel_fgnt", 32'(f_gnt), 1);
      chk("rrel_memaddr", mem_addr, 2);
      chk("rrel_no_stale", 32'(f_rvalid), 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rrel_frvalid", 32'(f_rvalid), 1);
      chk("rrel_frdata", f_rdata, 32'h1234ABCD);
      chk("rrel_ferr", 32'(f_err), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rrel_pulse_end", 32'(f_rvalid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
